// File: rtl/alu_muldiv_if.sv
// Issue/result bundle between the EX-stage controller and alu_muldiv_unit.
interface alu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       funct;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             ovf;
   logic             illegal;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output in_valid, funct, op_a, op_b,
      input  in_ready, out_valid, result, zero, ovf, illegal, hi, lo
   );

   modport slave (
      input  in_valid, funct, op_a, op_b,
      output in_ready, out_valid, result, zero, ovf, illegal, hi, lo
   );
endinterface

// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU: registered single-cycle funct ops plus iterative
// MULT/MULTU/DIV/DIVU writing architectural HI/LO.
module alu_muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   alu_muldiv_if.slave bus
);
   localparam logic [5:0] F_ADD  = 6'h20, F_SUB  = 6'h22, F_AND   = 6'h24, F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27, F_XOR  = 6'h13, F_SLT   = 6'h2A, F_SLTU = 6'h2B;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
   localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc, q, bm, hi_q, lo_q, res_q;
   logic             md_div, neg_q, neg_r, dz;
   logic             out_q, zero_q, ovf_q, ill_q, ready_c;

   logic [WIDTH-1:0] a, b, a_mag, b_mag;
   logic             is_md, is_div, is_sgn, a_neg, b_neg;

   assign a      = bus.op_a;
   assign b      = bus.op_b;
   assign is_md  = bus.funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
   assign is_div = bus.funct[1];
   assign is_sgn = ~bus.funct[0];
   assign a_neg  = is_sgn & a[WIDTH-1];
   assign b_neg  = is_sgn & b[WIDTH-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;

   // Single-cycle datapath
   logic [WIDTH-1:0] sum, diff, alu_res;
   logic             alu_ovf, alu_ill;
   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (bus.funct)
         F_ADD:  begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         F_SUB:  begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         F_AND:  alu_res = a & b;
         F_OR:   alu_res = a | b;
         F_NOR:  alu_res = ~(a | b);
         F_XOR:  alu_res = a ^ b;
         F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         F_MFHI: alu_res = hi_q;
         F_MFLO: alu_res = lo_q;
         F_MULT, F_MULTU, F_DIV, F_DIVU: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   // Iteration step: acc:q is the product shift pair, or remainder:dividend
   logic [WIDTH:0] mul_sum, div_shift, div_trial;
   assign mul_sum   = {1'b0, acc} + {1'b0, {WIDTH{q[0]}} & bm};
   assign div_shift = {acc, q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, bm};

   logic [2*WIDTH-1:0] prod, prod_fx;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   assign prod    = {acc, q};
   assign prod_fx = neg_q ? -prod : prod;

   always_comb begin
      fix_hi = prod_fx[2*WIDTH-1:WIDTH];
      fix_lo = prod_fx[WIDTH-1:0];
      if (md_div) begin
         // Restoring divide by zero already leaves rem=|a|, so HI=op_a after sign fix
         fix_lo = dz ? '1 : (neg_q ? -q : q);
         fix_hi = neg_r ? -acc : acc;
      end
   end

   always_comb begin
      state_d = state_q;
      ready_c = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.in_valid && is_md) state_d = ITER;
         end
         ITER: if (cnt == CNT_W'(WIDTH-1)) state_d = FIX;
         FIX:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0; acc <= '0; q <= '0; bm <= '0;
         hi_q <= '0; lo_q <= '0; res_q <= '0;
         md_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
         out_q <= 1'b0; zero_q <= 1'b0; ovf_q <= 1'b0; ill_q <= 1'b0;
      end else begin
         out_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.in_valid) begin
               if (is_md) begin
                  cnt    <= '0;
                  acc    <= '0;
                  md_div <= is_div;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  dz     <= (b == '0);
                  q      <= is_div ? a_mag : b_mag;
                  bm     <= is_div ? b_mag : a_mag;
               end else begin
                  out_q  <= 1'b1;
                  res_q  <= alu_res;
                  zero_q <= (alu_res == '0);
                  ovf_q  <= alu_ovf;
                  ill_q  <= alu_ill;
               end
            end
            ITER: begin
               cnt <= cnt + 1'b1;
               if (md_div) begin
                  acc <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                  q   <= {q[WIDTH-2:0], ~div_trial[WIDTH]};
               end else begin
                  acc <= mul_sum[WIDTH:1];
                  q   <= {mul_sum[0], q[WIDTH-1:1]};
               end
            end
            FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               res_q  <= fix_lo;
               zero_q <= (fix_lo == '0);
               ovf_q  <= 1'b0;
               ill_q  <= 1'b0;
               out_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = out_q;
   assign bus.result    = res_q;
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;
   assign bus.illegal   = ill_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit against an arithmetic reference model.
module tb_alu_muldiv_unit;
   localparam int W = 32;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_muldiv_if #(.WIDTH(W)) bus();
   alu_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   logic [W-1:0] m_hi, m_lo;
   logic [W-1:0] o_res, o_hi, o_lo;
   logic         o_zero, o_ovf, o_ill;
   int           o_lat, o_rdy_low;

   logic [5:0] legal_f [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h13, 6'h2A,
                                6'h2B, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};

   // Reference: updates m_hi/m_lo for mul/div, returns result and flags
   task automatic ref_model(input logic [5:0] f, input logic [W-1:0] a, b,
                            output logic [W-1:0] r, output bit ov, il, md);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint s;
      logic [63:0] p;
      r = '0; ov = 0; il = 0; md = 0;
      case (f)
         6'h20: begin s = sa + sb; r = W'(s); ov = (s > MAXS) || (s < MINS); end
         6'h22: begin s = sa - sb; r = W'(s); ov = (s > MAXS) || (s < MINS); end
         6'h24: r = a & b;
         6'h25: r = a | b;
         6'h27: r = ~(a | b);
         6'h13: r = a ^ b;
         6'h2A: r = (sa < sb) ? 1 : 0;
         6'h2B: r = (ua < ub) ? 1 : 0;
         6'h10: r = m_hi;
         6'h12: r = m_lo;
         6'h18, 6'h19: begin
            p = (f == 6'h18) ? 64'(sa * sb) : 64'(ua * ub);
            m_hi = p[63:32]; m_lo = p[31:0]; md = 1; r = m_lo;
         end
         6'h1A, 6'h1B: begin
            if (b == '0) begin m_lo = '1; m_hi = a; end
            else if (f == 6'h1A) begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
            else begin m_lo = W'(ua / ub); m_hi = W'(ua % ub); end
            md = 1; r = m_lo;
         end
         default: il = 1;
      endcase
   endtask

   // Issues one op from IDLE and captures the response pulse
   task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, b, input bit poke);
      bus.in_valid = 1'b1; bus.funct = f; bus.op_a = a; bus.op_b = b;
      @(posedge clk); #1;
      bus.in_valid = poke;
      if (poke) bus.funct = 6'h20;
      o_lat = 1; o_rdy_low = 0;
      while (!bus.out_valid && o_lat < 200) begin
         if (!bus.in_ready) o_rdy_low++;
         @(posedge clk); #1;
         o_lat++;
      end
      bus.in_valid = 1'b0;
      o_res = bus.result; o_hi = bus.hi; o_lo = bus.lo;
      o_zero = bus.zero; o_ovf = bus.ovf; o_ill = bus.illegal;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.in_valid = 1'b0; bus.funct = '0; bus.op_a = '0; bus.op_b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.zero, bus.ovf, bus.illegal} !== 5'b10000) begin
         errors++; $display("FAIL reset_flags: got %b expected 10000",
                            {bus.in_ready, bus.out_valid, bus.zero, bus.ovf, bus.illegal});
      end
      checks++;
      if ({bus.result, bus.hi, bus.lo} !== '0) begin
         errors++; $display("FAIL reset_regs: got %h %h %h expected zeros", bus.result, bus.hi, bus.lo);
      end
      rst = 1'b0; m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_add_ovf();
      do_op(6'h20, 32'h7FFFFFFF, 32'h00000001, 0);
      checks++;
      if (o_lat !== 1) begin errors++; $display("FAIL add_lat: got %0d expected 1", o_lat); end
      checks++;
      if ({o_res, o_ovf, o_zero} !== {32'h80000000, 1'b1, 1'b0}) begin
         errors++; $display("FAIL add_ovf: got %h ovf=%b zero=%b expected 80000000 ovf=1 zero=0",
                            o_res, o_ovf, o_zero);
      end
   endtask

   task automatic test_back_to_back();
      bus.in_valid = 1'b1; bus.funct = 6'h22; bus.op_a = 32'd5; bus.op_b = 32'd5;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.zero} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
         errors++; $display("FAIL b2b_sub: got v=%b r=%b %h z=%b expected v=1 r=1 0 z=1",
                            bus.out_valid, bus.in_ready, bus.result, bus.zero);
      end
      bus.funct = 6'h2A; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'h1;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.result, bus.zero} !== {1'b1, 32'h1, 1'b0}) begin
         errors++; $display("FAIL b2b_slt: got v=%b %h z=%b expected v=1 1 z=0",
                            bus.out_valid, bus.result, bus.zero);
      end
      bus.funct = 6'h2B;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.result, bus.zero} !== {1'b1, 32'h0, 1'b1}) begin
         errors++; $display("FAIL b2b_sltu: got v=%b %h z=%b expected v=1 0 z=1",
                            bus.out_valid, bus.result, bus.zero);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got v=%b expected 0", bus.out_valid); end
   endtask

   task automatic test_mult();
      logic [W-1:0] r; bit ov, il, md;
      ref_model(6'h18, 32'hFFFFFFFE, 32'h3, r, ov, il, md);
      do_op(6'h18, 32'hFFFFFFFE, 32'h3, 0);
      checks++;
      if (o_lat !== W + 2 || o_rdy_low !== W + 1) begin
         errors++; $display("FAIL mult_timing: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
                            o_lat, o_rdy_low, W + 2, W + 1);
      end
      checks++;
      if ({o_hi, o_lo, o_res} !== {32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFA}) begin
         errors++; $display("FAIL mult_val: got hi=%h lo=%h res=%h expected FFFFFFFF FFFFFFFA", o_hi, o_lo, o_res);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mult_ready: got %b expected 1", bus.in_ready); end
      do_op(6'h10, 32'h0, 32'h0, 0);
      checks++;
      if (o_res !== 32'hFFFFFFFF || o_lat !== 1) begin
         errors++; $display("FAIL mfhi: got %h lat=%0d expected FFFFFFFF lat=1", o_res, o_lat);
      end
   endtask

   task automatic test_div();
      logic [W-1:0] r; bit ov, il, md;
      ref_model(6'h1A, 32'hFFFFFFF9, 32'h2, r, ov, il, md);
      do_op(6'h1A, 32'hFFFFFFF9, 32'h2, 0);
      checks++;
      if ({o_lo, o_hi} !== {32'hFFFFFFFD, 32'hFFFFFFFF} || o_lat !== W + 2) begin
         errors++; $display("FAIL div_neg: got lo=%h hi=%h lat=%0d expected FFFFFFFD FFFFFFFF %0d", o_lo, o_hi, o_lat, W + 2);
      end
      ref_model(6'h1B, 32'hA, 32'h0, r, ov, il, md);
      do_op(6'h1B, 32'hA, 32'h0, 0);
      checks++;
      if ({o_lo, o_hi} !== {32'hFFFFFFFF, 32'h0000000A} || o_lat !== W + 2) begin
         errors++; $display("FAIL divu_zero: got lo=%h hi=%h lat=%0d expected FFFFFFFF 0000000A %0d", o_lo, o_hi, o_lat, W + 2);
      end
      ref_model(6'h1A, 32'h80000000, 32'hFFFFFFFF, r, ov, il, md);
      do_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, 0);
      checks++;
      if ({o_lo, o_hi} !== {32'h80000000, 32'h0}) begin
         errors++; $display("FAIL div_minneg: got lo=%h hi=%h expected 80000000 00000000", o_lo, o_hi);
      end
      ref_model(6'h1A, 32'hFFFFFFF9, 32'h0, r, ov, il, md);
      do_op(6'h1A, 32'hFFFFFFF9, 32'h0, 0);
      checks++;
      if ({o_lo, o_hi} !== {32'hFFFFFFFF, 32'hFFFFFFF9}) begin
         errors++; $display("FAIL div_zero_s: got lo=%h hi=%h expected FFFFFFFF FFFFFFF9", o_lo, o_hi);
      end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] r; bit ov, il, md;
      int pulses = 0;
      bus.in_valid = 1'b1; bus.funct = 6'h19; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'hFFFFFFFF;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m_hi = '0; m_lo = '0;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.hi, bus.lo} !== {1'b1, 1'b0, 64'h0}) begin
         errors++; $display("FAIL abort_state: got rdy=%b v=%b hi=%h lo=%h expected 1 0 0 0",
                            bus.in_ready, bus.out_valid, bus.hi, bus.lo);
      end
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) pulses++;
         @(posedge clk); #1;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL abort_pulse: got %0d expected 0", pulses); end
      ref_model(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, r, ov, il, md);
      do_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      checks++;
      if ({o_hi, o_lo} !== {32'hFFFFFFFE, 32'h00000001}) begin
         errors++; $display("FAIL multu_reissue: got hi=%h lo=%h expected FFFFFFFE 00000001", o_hi, o_lo);
      end
   endtask

   task automatic test_illegal();
      logic [W-1:0] r; bit ov, il, md;
      int pulses = 0;
      ref_model(6'h1B, 32'd1000, 32'd7, r, ov, il, md);
      do_op(6'h1B, 32'd1000, 32'd7, 0);
      do_op(6'h3F, 32'h12345678, 32'h9ABCDEF0, 0);
      checks++;
      if ({o_lat == 1, o_ill, o_res} !== {1'b1, 1'b1, 32'h0}) begin
         errors++; $display("FAIL illegal: got lat=%0d ill=%b res=%h expected lat=1 ill=1 0", o_lat, o_ill, o_res);
      end
      checks++;
      if ({o_hi, o_lo} !== {32'd6, 32'd142}) begin
         errors++; $display("FAIL illegal_hilo: got hi=%h lo=%h expected 6 8e", o_hi, o_lo);
      end
      ref_model(6'h18, 32'hFFFFFFFD, 32'd5, r, ov, il, md);
      do_op(6'h18, 32'hFFFFFFFD, 32'd5, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) pulses++;
      end
      checks++;
      if (o_lat !== W + 2 || pulses !== 0 || {o_hi, o_lo} !== {m_hi, m_lo}) begin
         errors++; $display("FAIL busy_ignore: got lat=%0d extra=%0d hi=%h lo=%h expected lat=%0d extra=0 hi=%h lo=%h",
                            o_lat, pulses, o_hi, o_lo, W + 2, m_hi, m_lo);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, r;
      logic [5:0] f;
      bit ov, il, md;
      for (int n = 0; n < 60; n++) begin
         f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 13)];
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: a = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            3: b = 32'($urandom_range(1, 20));
            default: ;
         endcase
         ref_model(f, a, b, r, ov, il, md);
         do_op(f, a, b, 0);
         checks++;
         if (o_lat !== (md ? W + 2 : 1)) begin
            errors++; $display("FAIL rnd_lat f=%h: got %0d expected %0d", f, o_lat, md ? W + 2 : 1);
         end
         checks++;
         if ({o_res, o_zero, o_ill} !== {r, r == '0, il}) begin
            errors++; $display("FAIL rnd_res f=%h a=%h b=%h: got %h z=%b ill=%b expected %h z=%b ill=%b",
                               f, a, b, o_res, o_zero, o_ill, r, r == '0, il);
         end
         checks++;
         if ({o_hi, o_lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL rnd_hilo f=%h a=%h b=%h: got %h %h expected %h %h", f, a, b, o_hi, o_lo, m_hi, m_lo);
         end
         if (f == 6'h20 || f == 6'h22) begin
            checks++;
            if (o_ovf !== ov) begin
               errors++; $display("FAIL rnd_ovf f=%h a=%h b=%h: got %b expected %b", f, a, b, o_ovf, ov);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_ovf();
      test_back_to_back();
      test_mult();
      test_div();
      test_reset_abort();
      test_illegal();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
